// File: rtl/mac_pipeline_multi_pkg.sv
// Shared parameters and stage-1 control bundle for the mac_pipeline_multi MAC block.
package mac_pipeline_multi_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_GUARD_BITS     = 4;
    localparam int unsigned DEF_LANES          = 2;
    localparam int unsigned DEF_DATA_OUT_WIDTH = 2 * DEF_DATA_WIDTH + DEF_GUARD_BITS;

    // Control bits piped alongside each sample into stage 2.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic mode;
    } ctrl_t;

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: stage-1 product/C registers, stage-2 accumulator and result register.
// Saturation and the sticky overflow flag exist only when MAC_SATURATE_EN is defined.
module mac_lane
    import mac_pipeline_multi_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned GUARD_BITS = DEF_GUARD_BITS,
    localparam int unsigned OUT_WIDTH  = 2 * DATA_WIDTH + GUARD_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    input  ctrl_t                 s1_ctrl,
    output logic [OUT_WIDTH-1:0]  data_out,
    output logic                  overflow
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    logic [PROD_WIDTH-1:0] prod_q, prod_d;
    logic [DATA_WIDTH-1:0] c_q, c_d;
    logic [OUT_WIDTH-1:0]  acc_q, acc_d;
    logic [OUT_WIDTH-1:0]  dout_q, dout_d;
    logic [OUT_WIDTH-1:0]  base;
    logic [OUT_WIDTH-1:0]  sum;
    logic                  emit;

    // Stage 1 captures operands only on a valid sample.
    always_comb begin
        prod_d = prod_q;
        c_d    = c_q;
        if (in_valid) begin
            prod_d = PROD_WIDTH'(a) * PROD_WIDTH'(b);
            c_d    = c;
        end
    end

    // Framed samples without a first flag continue the running sum; all others seed with C.
    always_comb begin
        emit = s1_ctrl.valid & (~s1_ctrl.mode | s1_ctrl.last);
        base = (s1_ctrl.mode & ~s1_ctrl.first) ? acc_q : OUT_WIDTH'(c_q);
    end

`ifdef MAC_SATURATE_EN
    localparam int unsigned SUM_WIDTH = OUT_WIDTH + 1;

    logic [SUM_WIDTH-1:0] sum_wide;
    logic                 ovf_q, ovf_d;

    always_comb begin
        sum_wide = SUM_WIDTH'(base) + SUM_WIDTH'(prod_q);
        sum      = sum_wide[SUM_WIDTH-1] ? '1 : sum_wide[OUT_WIDTH-1:0];
        ovf_d    = ovf_q;
        if (s1_ctrl.valid && sum_wide[SUM_WIDTH-1]) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    always_comb begin
        sum = base + OUT_WIDTH'(prod_q);
    end

    assign overflow = 1'b0;
`endif

    // Accumulator follows every valid sample; the visible result only changes when emitted.
    always_comb begin
        acc_d  = acc_q;
        dout_d = dout_q;
        if (s1_ctrl.valid) begin
            acc_d = sum;
            if (emit) begin
                dout_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            c_q    <= '0;
            acc_q  <= '0;
            dout_q <= '0;
        end else begin
            prod_q <= prod_d;
            c_q    <= c_d;
            acc_q  <= acc_d;
            dout_q <= dout_d;
        end
    end

    assign data_out = dout_q;

endmodule

// File: rtl/mac_pipeline_multi.sv
// Multi-lane two-stage MAC with per-sample and framed accumulation modes.
// Define MAC_SATURATE_EN to clamp on overflow and drive the sticky overflow flags.
module mac_pipeline_multi
    import mac_pipeline_multi_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter  int unsigned GUARD_BITS     = DEF_GUARD_BITS,
    parameter  int unsigned LANES          = DEF_LANES,
    localparam int unsigned DATA_OUT_WIDTH = 2 * DATA_WIDTH + GUARD_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic                          acc_mode,
    input  logic [LANES*DATA_WIDTH-1:0]   A,
    input  logic [LANES*DATA_WIDTH-1:0]   B,
    input  logic [LANES*DATA_WIDTH-1:0]   C,
    output logic [LANES*DATA_OUT_WIDTH-1:0] DATA_OUT,
    output logic                          out_valid,
    output logic [LANES-1:0]              overflow
);

    ctrl_t ctrl_q, ctrl_d;
    logic  out_valid_q, out_valid_d;

    // Control pipeline shared by every lane; per-sample results always emit, framed only on last.
    always_comb begin
        ctrl_d.valid = in_valid;
        ctrl_d.first = in_first;
        ctrl_d.last  = in_last;
        ctrl_d.mode  = acc_mode;
        out_valid_d  = ctrl_q.valid & (~ctrl_q.mode | ctrl_q.last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .GUARD_BITS (GUARD_BITS)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid),
            .a        (A[i*DATA_WIDTH +: DATA_WIDTH]),
            .b        (B[i*DATA_WIDTH +: DATA_WIDTH]),
            .c        (C[i*DATA_WIDTH +: DATA_WIDTH]),
            .s1_ctrl  (ctrl_q),
            .data_out (DATA_OUT[i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH]),
            .overflow (overflow[i])
        );
    end

endmodule

// File: tb/tb_mac_pipeline_multi.sv
// Self-checking bench for mac_pipeline_multi against an arithmetic reference model.
module tb_mac_pipeline_multi;
    import mac_pipeline_multi_pkg::*;

    localparam int unsigned DW   = DEF_DATA_WIDTH;
    localparam int unsigned L    = DEF_LANES;
    localparam int unsigned OW   = DEF_DATA_OUT_WIDTH;
    localparam longint      MAXV = (longint'(1) << OW) - 1;

    logic            clk = 1'b0;
    logic            reset, in_valid, in_first, in_last, acc_mode;
    logic [L*DW-1:0] A, B, C;
    logic [L*OW-1:0] DATA_OUT;
    logic            out_valid;
    logic [L-1:0]    overflow;

    int errors = 0;
    int checks = 0;

    longint          m_acc [L];
    logic            exp_ov;
    logic [L*OW-1:0] exp_do;
    logic [L-1:0]    exp_ovf;
    logic            pend_v;
    logic [L*OW-1:0] pend_do;
    logic [L-1:0]    pend_ovf;

    always #5 clk = ~clk;

    mac_pipeline_multi dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .acc_mode  (acc_mode),
        .A         (A),
        .B         (B),
        .C         (C),
        .DATA_OUT  (DATA_OUT),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    function automatic logic [L*DW-1:0] rv();
        return (L*DW)'($urandom);
    endfunction

    function automatic logic [L*DW-1:0] lanes(input logic [DW-1:0] l0, input logic [DW-1:0] l1);
        return {l1, l0};
    endfunction

    // Drive one cycle, then advance the model: results appear one edge after capture.
    task automatic tick(input logic rst, input logic v, input logic f, input logic l, input logic m,
                        input logic [L*DW-1:0] a, input logic [L*DW-1:0] b, input logic [L*DW-1:0] c);
        longint base, sum;
        @(negedge clk);
        reset = rst; in_valid = v; in_first = f; in_last = l; acc_mode = m;
        A = a; B = b; C = c;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_ov = 1'b0; exp_do = '0; exp_ovf = '0;
            pend_v = 1'b0; pend_ovf = '0;
            for (int i = 0; i < int'(L); i++) m_acc[i] = 0;
        end else begin
            exp_ov  = pend_v;
            if (pend_v) exp_do = pend_do;
            exp_ovf = pend_ovf;
            pend_v  = v && (!m || l);
            if (v) begin
                for (int i = 0; i < int'(L); i++) begin
                    base = (m && !f) ? m_acc[i] : longint'(c[i*DW +: DW]);
                    sum  = base + longint'(a[i*DW +: DW]) * longint'(b[i*DW +: DW]);
                    if (sum > MAXV) begin
`ifdef MAC_SATURATE_EN
                        sum = MAXV;
                        pend_ovf[i] = 1'b1;
`else
                        sum = sum % (MAXV + 1);
`endif
                    end
                    m_acc[i] = sum;
                    pend_do[i*OW +: OW] = OW'(sum);
                end
            end
        end
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, rv(), rv(), rv());
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rv(), rv(), rv());
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        checks++;
        if (DATA_OUT !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", DATA_OUT); end
        checks++;
        if (overflow !== '0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rv(), rv(), rv());
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_cycle_sample got=%0b want=0", out_valid); end
    endtask

    task automatic test_per_sample();
        logic [OW-1:0] l0, l1;
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, lanes(3, 255), lanes(4, 255), lanes(5, 255));
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ps_latency got=%0b want=0", out_valid); end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rv(), rv(), rv());
        l0 = DATA_OUT[0 +: OW];
        l1 = DATA_OUT[OW +: OW];
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ps_valid got=%0b want=1", out_valid); end
        checks++;
        if (l0 !== OW'(17)) begin errors++; $display("FAIL ps_lane0 got=%0d want=17", l0); end
        checks++;
        if (l1 !== OW'(65280)) begin errors++; $display("FAIL ps_lane1 got=%0d want=65280", l1); end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rv(), rv(), rv());
        l0 = DATA_OUT[0 +: OW];
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ps_pulse got=%0b want=0", out_valid); end
        checks++;
        if (l0 !== OW'(17)) begin errors++; $display("FAIL ps_hold got=%0d want=17", l0); end
        for (int t = 0; t < 24; t++) begin
            tick(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'b0, rv(), rv(), rv());
            checks++;
            if (out_valid !== exp_ov) begin errors++; $display("FAIL ps_rand_valid t=%0d got=%0b want=%0b", t, out_valid, exp_ov); end
            checks++;
            if (DATA_OUT !== exp_do) begin errors++; $display("FAIL ps_rand_data t=%0d got=%h want=%h", t, DATA_OUT, exp_do); end
        end
    endtask

    task automatic test_framed();
        logic [DW-1:0] a0 [3] = '{8'd2, 8'd4, 8'd1};
        logic [DW-1:0] b0 [3] = '{8'd3, 8'd5, 8'd1};
        logic [DW-1:0] c0 [3] = '{8'd10, 8'd99, 8'd77};
        logic [OW-1:0] l0;
        for (int t = 0; t < 6; t++) begin
            if (t < 3)
                tick(1'b0, 1'b1, 1'(t == 0), 1'(t == 2), 1'b1,
                     lanes(a0[t], DW'($urandom)), lanes(b0[t], DW'($urandom)), lanes(c0[t], DW'($urandom)));
            else
                tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rv(), rv(), rv());
            l0 = DATA_OUT[0 +: OW];
            checks++;
            if (out_valid !== exp_ov) begin errors++; $display("FAIL framed_valid t=%0d got=%0b want=%0b", t, out_valid, exp_ov); end
            checks++;
            if (DATA_OUT !== exp_do) begin errors++; $display("FAIL framed_data t=%0d got=%h want=%h", t, DATA_OUT, exp_do); end
            if (t == 3) begin
                checks++;
                if (out_valid !== 1'b1 || l0 !== OW'(37)) begin
                    errors++; $display("FAIL framed_37 valid=%0b got=%0d want=37", out_valid, l0);
                end
            end
        end
    endtask

    task automatic test_single_frame();
        logic [OW-1:0] l0;
        for (int t = 0; t < 6; t++) begin
            if (t == 2)
                tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, lanes(7, DW'($urandom)), lanes(7, DW'($urandom)), lanes(1, DW'($urandom)));
            else
                tick(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b1, rv(), rv(), rv());
            l0 = DATA_OUT[0 +: OW];
            checks++;
            if (out_valid !== exp_ov) begin errors++; $display("FAIL single_valid t=%0d got=%0b want=%0b", t, out_valid, exp_ov); end
            checks++;
            if (DATA_OUT !== exp_do) begin errors++; $display("FAIL single_data t=%0d got=%h want=%h", t, DATA_OUT, exp_do); end
            if (t >= 3) begin
                checks++;
                if (l0 !== OW'(50)) begin errors++; $display("FAIL single_50 t=%0d got=%0d want=50", t, l0); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [OW-1:0] l0, l1;
        for (int t = 0; t < 6; t++) begin
            case (t)
                0: tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, rv(), rv(), rv());
                1: tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, rv(), rv(), rv());
                2: tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, rv(), rv(), rv());
                3: tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, lanes(1, 2), lanes(1, 3), lanes(0, 4));
                default: tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rv(), rv(), rv());
            endcase
            l0 = DATA_OUT[0 +: OW];
            l1 = DATA_OUT[OW +: OW];
            checks++;
            if (out_valid !== exp_ov) begin errors++; $display("FAIL rmf_valid t=%0d got=%0b want=%0b", t, out_valid, exp_ov); end
            checks++;
            if (DATA_OUT !== exp_do) begin errors++; $display("FAIL rmf_data t=%0d got=%h want=%h", t, DATA_OUT, exp_do); end
            if (t == 2 || t == 3) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL rmf_spurious t=%0d got=%0b want=0", t, out_valid); end
            end
            if (t == 4) begin
                checks++;
                if (out_valid !== 1'b1 || l0 !== OW'(1) || l1 !== OW'(10)) begin
                    errors++; $display("FAIL rmf_result valid=%0b got=%0d,%0d want=1,10", out_valid, l0, l1);
                end
            end
        end
    endtask

    task automatic test_saturate();
        logic [OW-1:0] l0, want;
        logic [L-1:0]  want_ovf;
`ifdef MAC_SATURATE_EN
        want     = OW'(MAXV);
        want_ovf = '1;
`else
        want     = OW'((20 * 65025) % (1 << 20));
        want_ovf = '0;
`endif
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rv(), rv(), rv());
        for (int t = 0; t < 24; t++) begin
            if (t < 20)
                tick(1'b0, 1'b1, 1'(t == 0), 1'(t == 19), 1'b1, lanes(255, 255), lanes(255, 255), '0);
            else
                tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, lanes(1, 1), lanes(1, 1), '0);
            l0 = DATA_OUT[0 +: OW];
            checks++;
            if (out_valid !== exp_ov) begin errors++; $display("FAIL sat_valid t=%0d got=%0b want=%0b", t, out_valid, exp_ov); end
            checks++;
            if (DATA_OUT !== exp_do) begin errors++; $display("FAIL sat_data t=%0d got=%h want=%h", t, DATA_OUT, exp_do); end
            checks++;
            if (overflow !== exp_ovf) begin errors++; $display("FAIL sat_ovf t=%0d got=%b want=%b", t, overflow, exp_ovf); end
            if (t == 20) begin
                checks++;
                if (out_valid !== 1'b1 || l0 !== want) begin errors++; $display("FAIL sat_result got=%0d want=%0d", l0, want); end
            end
            if (t == 23) begin
                checks++;
                if (overflow !== want_ovf) begin errors++; $display("FAIL sat_sticky got=%b want=%b", overflow, want_ovf); end
            end
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rv(), rv(), rv());
        checks++;
        if (overflow !== '0) begin errors++; $display("FAIL sat_reset_clear got=%b want=0", overflow); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            tick(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom), rv(), rv(), rv());
            checks++;
            if (out_valid !== exp_ov) begin errors++; $display("FAIL rand_valid t=%0d got=%0b want=%0b", t, out_valid, exp_ov); end
            checks++;
            if (DATA_OUT !== exp_do) begin errors++; $display("FAIL rand_data t=%0d got=%h want=%h", t, DATA_OUT, exp_do); end
            checks++;
            if (overflow !== exp_ovf) begin errors++; $display("FAIL rand_ovf t=%0d got=%b want=%b", t, overflow, exp_ovf); end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; acc_mode = 1'b0;
        A = '0; B = '0; C = '0;
        exp_ov = 1'b0; exp_do = '0; exp_ovf = '0;
        pend_v = 1'b0; pend_do = '0; pend_ovf = '0;
        for (int i = 0; i < int'(L); i++) m_acc[i] = 0;
        test_reset();
        test_per_sample();
        test_framed();
        test_single_frame();
        test_reset_mid_frame();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
